// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle load/store controller:
// size encodings, FSM state codes, default ack timeout and the alignment rule.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  // Transfer size encodings
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Default number of un-acked request cycles before aborting
  localparam int unsigned DEF_TIMEOUT = 15;

  // True when the access cannot be issued: illegal size or unaligned offset
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (sz)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
// Purely combinational.
//   size      : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   off       : byte offset within the word (addr[1:0])
//   sign_ext  : 1 sign-extends loaded byte/half, 0 zero-extends
//   wdata     : store data, low bits used for byte/half
//   rdata_raw : full word returned by memory
//   be_c      : byte enables, little-endian lanes
//   wdata_c   : lane-replicated store data
//   ldata_c   : extracted and extended load value
module lane_align
  import mem_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        off,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata_raw,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] ldata_c
);

  logic [DATA_W-1:0] shifted;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Store-side lane enables and replicated data
  always_comb begin
    be_c    = '0;
    wdata_c = wdata;
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = 4'b0011 << off;
        wdata_c = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
      default: begin
        be_c    = '0;
        wdata_c = wdata;
      end
    endcase
  end

  // Load-side: bring the addressed lane down to bit 0, then extend
  assign shifted = rdata_raw >> {off, 3'b000};
  assign byte_v  = shifted[7:0];
  assign half_v  = shifted[15:0];

  always_comb begin
    ldata_c = rdata_raw;
    case (size)
      SZ_BYTE: ldata_c = sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      SZ_HALF: ldata_c = sign_ext ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
      default: ldata_c = rdata_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multicycle load/store controller between the CPU address register and a
// single-port memory with a req/ack handshake and variable wait states.
//   start/is_store/size/sign_ext/addr/wdata : request from the control FSM
//   busy, done, err_misalign, err_timeout   : status back to the control FSM
//   rdata                                   : last successfully loaded value
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata : memory request side
//   mem_rdata/mem_ack                        : memory response side
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err_misalign,
  output logic              err_timeout,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [BE_W-1:0]   mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t            state_q, state_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [1:0]        size_q, size_n;
  logic [1:0]        off_q, off_n;
  logic              sext_q, sext_n;
  logic              store_q, store_n;

  logic              busy_n, done_n, err_mis_n, err_to_n, mem_req_n, mem_we_n;
  logic [BE_W-1:0]   mem_be_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [DATA_W-1:0] mem_wdata_n, rdata_n;

  logic [1:0]        la_size, la_off;
  logic              la_sext;
  logic [BE_W-1:0]   la_be;
  logic [DATA_W-1:0] la_wdata, la_ldata;

  // In IDLE the aligner sees the incoming request (store lanes); afterwards
  // it sees the captured access (load extraction).
  always_comb begin
    la_size = size_q;
    la_off  = off_q;
    la_sext = sext_q;
    if (state_q == ST_IDLE) begin
      la_size = size;
      la_off  = addr[1:0];
      la_sext = sign_ext;
    end
  end

  lane_align u_lane_align (
    .size      (la_size),
    .off       (la_off),
    .sign_ext  (la_sext),
    .wdata     (wdata),
    .rdata_raw (mem_rdata),
    .be_c      (la_be),
    .wdata_c   (la_wdata),
    .ldata_c   (la_ldata)
  );

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    size_n      = size_q;
    off_n       = off_q;
    sext_n      = sext_q;
    store_n     = store_q;
    busy_n      = busy;
    done_n      = 1'b0;
    err_mis_n   = 1'b0;
    err_to_n    = 1'b0;
    rdata_n     = rdata;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_be_n    = mem_be;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_misaligned(size, addr[1:0])) begin
            state_n   = ST_DONE;
            done_n    = 1'b1;
            err_mis_n = 1'b1;
          end else begin
            state_n     = ST_REQ;
            cnt_n       = '0;
            size_n      = size;
            off_n       = addr[1:0];
            sext_n      = sign_ext;
            store_n     = is_store;
            busy_n      = 1'b1;
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_be_n    = la_be;
            mem_addr_n  = {addr[ADDR_W-1:2], 2'b00};
            mem_wdata_n = la_wdata;
          end
        end
      end
      ST_REQ: begin
        // Ack wins over a timeout landing in the same cycle
        if (mem_ack) begin
          state_n   = ST_DONE;
          done_n    = 1'b1;
          busy_n    = 1'b0;
          mem_req_n = 1'b0;
          if (!store_q) rdata_n = la_ldata;
        end else if (cnt_q + CNT_W'(1) == TO_LIM) begin
          state_n   = ST_DONE;
          done_n    = 1'b1;
          err_to_n  = 1'b1;
          busy_n    = 1'b0;
          mem_req_n = 1'b0;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n   = ST_IDLE;
        busy_n    = 1'b0;
        mem_req_n = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= SZ_BYTE;
      off_q        <= '0;
      sext_q       <= 1'b0;
      store_q      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      rdata        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      size_q       <= size_n;
      off_q        <= off_n;
      sext_q       <= sext_n;
      store_q      <= store_n;
      busy         <= busy_n;
      done         <= done_n;
      err_misalign <= err_mis_n;
      err_timeout  <= err_to_n;
      rdata        <= rdata_n;
      mem_req      <= mem_req_n;
      mem_we       <= mem_we_n;
      mem_be       <= mem_be_n;
      mem_addr     <= mem_addr_n;
      mem_wdata    <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with TIMEOUT=4.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err_misalign, err_timeout;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Results of the last access
  int          r_done_cyc, r_req_cyc;
  logic        r_busy1, r_we, r_em, r_et;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata;

  mem_access_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .err_misalign(err_misalign), .err_timeout(err_timeout), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Pulse start (accepted at edge 0), then walk cycles 1.. until done.
  // ack_cyc = cycle in which mem_ack is high (0 = never); st_cyc = cycle in
  // which an extra start is pulsed (0 = none). done_cyc = 0 if no done seen.
  task automatic do_access(input logic st, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input int ack_cyc, input int st_cyc);
    is_store = st; size = sz; sign_ext = sx; addr = a; wdata = wd; mem_rdata = rd;
    r_done_cyc = 0; r_req_cyc = 0;
    r_busy1 = 1'b0; r_we = 1'b0; r_em = 1'b0; r_et = 1'b0;
    r_be = '0; r_addr = '0; r_wdata = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 1) begin
        r_busy1 = busy; r_we = mem_we; r_be = mem_be; r_addr = mem_addr; r_wdata = mem_wdata;
      end
      if (mem_req) r_req_cyc++;
      if (done) begin
        r_done_cyc = c; r_em = err_misalign; r_et = err_timeout;
        break;
      end
      mem_ack = (c == ack_cyc);
      start   = (c == st_cyc);
      @(negedge clk);
    end
    mem_ack = 1'b0;
    start   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({busy, done, err_misalign, err_timeout, mem_req, mem_we} !== 6'b0) begin
      n_err++; $display("FAIL rst_ctrl got %b exp 000000", {busy, done, err_misalign, err_timeout, mem_req, mem_we}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h exp 0", rdata); end
    n_cmp++; if ({mem_be, mem_addr, mem_wdata} !== 68'h0) begin
      n_err++; $display("FAIL rst_bus got %h/%h/%h exp 0", mem_be, mem_addr, mem_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_store();
    do_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 3, 0);
    n_cmp++; if (r_done_cyc !== 4) begin n_err++; $display("FAIL ws_done_cyc got %0d exp 4", r_done_cyc); end
    n_cmp++; if (r_req_cyc !== 3) begin n_err++; $display("FAIL ws_req_cyc got %0d exp 3", r_req_cyc); end
    n_cmp++; if (r_be !== 4'b1111) begin n_err++; $display("FAIL ws_be got %b exp 1111", r_be); end
    n_cmp++; if (r_addr !== 32'h100) begin n_err++; $display("FAIL ws_addr got %h exp 100", r_addr); end
    n_cmp++; if (r_we !== 1'b1) begin n_err++; $display("FAIL ws_we got %b exp 1", r_we); end
    n_cmp++; if (r_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL ws_wdata got %h exp deadbeef", r_wdata); end
    n_cmp++; if (r_busy1 !== 1'b1) begin n_err++; $display("FAIL ws_busy got %b exp 1", r_busy1); end
    n_cmp++; if ({r_em, r_et} !== 2'b00) begin n_err++; $display("FAIL ws_err got %b exp 00", {r_em, r_et}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL ws_rdata got %h exp 0", rdata); end
  endtask

  task automatic test_loads();
    do_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80112233, 1, 0);
    n_cmp++; if (r_done_cyc !== 2) begin n_err++; $display("FAIL lbs_done_cyc got %0d exp 2", r_done_cyc); end
    n_cmp++; if (r_be !== 4'b1000) begin n_err++; $display("FAIL lbs_be got %b exp 1000", r_be); end
    n_cmp++; if ({r_we, r_addr} !== {1'b0, 32'h200}) begin n_err++; $display("FAIL lbs_we_addr got %b/%h exp 0/200", r_we, r_addr); end
    n_cmp++; if (rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lbs_rdata got %h exp ffffff80", rdata); end
    do_access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80112233, 1, 0);
    n_cmp++; if (rdata !== 32'h00000080) begin n_err++; $display("FAIL lbz_rdata got %h exp 00000080", rdata); end
    do_access(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h9ABC1234, 2, 0);
    n_cmp++; if (r_be !== 4'b1100) begin n_err++; $display("FAIL lhs_be got %b exp 1100", r_be); end
    n_cmp++; if (r_done_cyc !== 3) begin n_err++; $display("FAIL lhs_done_cyc got %0d exp 3", r_done_cyc); end
    n_cmp++; if (rdata !== 32'hFFFF9ABC) begin n_err++; $display("FAIL lhs_rdata got %h exp ffff9abc", rdata); end
    do_access(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'h9ABC8234, 1, 0);
    n_cmp++; if (rdata !== 32'h00008234) begin n_err++; $display("FAIL lhz_rdata got %h exp 00008234", rdata); end
  endtask

  task automatic test_stores();
    do_access(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 32'hFFFFFFFF, 2, 0);
    n_cmp++; if (r_be !== 4'b1100) begin n_err++; $display("FAIL hs_be got %b exp 1100", r_be); end
    n_cmp++; if (r_wdata !== 32'hABCDABCD) begin n_err++; $display("FAIL hs_wdata got %h exp abcdabcd", r_wdata); end
    n_cmp++; if (r_addr !== 32'h10) begin n_err++; $display("FAIL hs_addr got %h exp 10", r_addr); end
    n_cmp++; if (rdata !== 32'h00008234) begin n_err++; $display("FAIL hs_rdata got %h exp 00008234", rdata); end
    do_access(1'b1, 2'b00, 1'b0, 32'h5, 32'h1234565A, 32'h0, 1, 0);
    n_cmp++; if (r_be !== 4'b0010) begin n_err++; $display("FAIL bs_be got %b exp 0010", r_be); end
    n_cmp++; if (r_wdata !== 32'h5A5A5A5A) begin n_err++; $display("FAIL bs_wdata got %h exp 5a5a5a5a", r_wdata); end
  endtask

  task automatic test_misalign();
    do_access(1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 32'h11111111, 1, 0);
    n_cmp++; if (r_done_cyc !== 1) begin n_err++; $display("FAIL mis_done_cyc got %0d exp 1", r_done_cyc); end
    n_cmp++; if ({r_em, r_et} !== 2'b10) begin n_err++; $display("FAIL mis_err got %b exp 10", {r_em, r_et}); end
    n_cmp++; if (r_req_cyc !== 0) begin n_err++; $display("FAIL mis_req_cyc got %0d exp 0", r_req_cyc); end
    n_cmp++; if (r_busy1 !== 1'b0) begin n_err++; $display("FAIL mis_busy got %b exp 0", r_busy1); end
    n_cmp++; if (rdata !== 32'h00008234) begin n_err++; $display("FAIL mis_rdata got %h exp 00008234", rdata); end
    n_cmp++; if (err_misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear got %b exp 0", err_misalign); end
    do_access(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1, 0);
    n_cmp++; if ({r_done_cyc, r_em, r_req_cyc} !== {32'd1, 1'b1, 32'd0}) begin
      n_err++; $display("FAIL sz11 got done=%0d em=%b req=%0d exp 1/1/0", r_done_cyc, r_em, r_req_cyc); end
    do_access(1'b1, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1, 0);
    n_cmp++; if ({r_done_cyc, r_em} !== {32'd1, 1'b1}) begin
      n_err++; $display("FAIL wmis got done=%0d em=%b exp 1/1", r_done_cyc, r_em); end
  endtask

  task automatic test_timeout();
    do_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 0, 2);
    n_cmp++; if (r_req_cyc !== 4) begin n_err++; $display("FAIL to_req_cyc got %0d exp 4", r_req_cyc); end
    n_cmp++; if (r_done_cyc !== 5) begin n_err++; $display("FAIL to_done_cyc got %0d exp 5", r_done_cyc); end
    n_cmp++; if ({r_em, r_et} !== 2'b01) begin n_err++; $display("FAIL to_err got %b exp 01", {r_em, r_et}); end
    n_cmp++; if (rdata !== 32'h00008234) begin n_err++; $display("FAIL to_rdata got %h exp 00008234", rdata); end
    n_cmp++; if ({busy, mem_req, err_timeout} !== 3'b000) begin
      n_err++; $display("FAIL to_after got %b exp 000", {busy, mem_req, err_timeout}); end
    // Ack in the cycle the counter reaches the limit is a success
    do_access(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11223344, 4, 0);
    n_cmp++; if ({r_done_cyc, r_et} !== {32'd5, 1'b0}) begin
      n_err++; $display("FAIL to_edge got done=%0d et=%b exp 5/0", r_done_cyc, r_et); end
    n_cmp++; if (rdata !== 32'h11223344) begin n_err++; $display("FAIL to_edge_rdata got %h exp 11223344", rdata); end
  endtask

  task automatic test_reset_mid_req();
    int seen_done;
    is_store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h40; mem_rdata = 32'h55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rm_req1 got %b exp 1", mem_req); end
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({mem_req, busy, done} !== 3'b000) begin
      n_err++; $display("FAIL rm_async got %b exp 000", {mem_req, busy, done}); end
    n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rm_rdata got %h exp 0", rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_req) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL rm_no_done got %0d exp 0", seen_done); end
    do_access(1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'h0000F700, 2, 0);
    n_cmp++; if ({r_done_cyc, r_em, r_et} !== {32'd3, 2'b00}) begin
      n_err++; $display("FAIL rm_after got done=%0d err=%b exp 3/00", r_done_cyc, {r_em, r_et}); end
    n_cmp++; if (rdata !== 32'hFFFFFFF7) begin n_err++; $display("FAIL rm_after_rdata got %h exp fffffff7", rdata); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word_store();
    test_loads();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multicycle load/store controller sitting directly downstream of the 32-bit address register in the multicycle CPU. It accepts a latched effective address plus operation from the control FSM. It drives a single-port memory through a req/ack handshake with variable wait states and returns load data in an internal MDR-style register. It handles byte/half/word sizing, byte-lane steering, sign extension, misalignment and ack timeout.

## Interface
- TIMEOUT, 15: max cycles mem_req is held without mem_ack before aborting (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request from control FSM; sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal and is treated as misaligned
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend
- addr  in  32  effective address from the address register
- wdata  in  32  store data; low bits are used for byte/half
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- err_misalign  out  1  valid with done
- err_timeout  out  1  valid with done
- rdata  out  32  last successfully loaded value, extended to 32 bits
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_be  out  4  byte enables, little-endian lanes
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  read data, valid when mem_ack is high
- mem_ack  in  1  transfer complete

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, start=1, aligned: capture addr, op, size, sign_ext and wdata, then go to REQ. Aligned means half needs addr[0]=0 and word needs addr[1:0]=0.
- IDLE, start=1, misaligned or size=11: go to DONE with err_misalign=1. No mem_req is issued.
- REQ: mem_req=1. mem_we, mem_be, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - On ack: a load updates rdata; go to DONE with both err flags 0.
  - Wait counter increments on each REQ cycle without ack. When it reaches TIMEOUT: drop mem_req, set err_timeout=1, go to DONE. rdata is unchanged.
- DONE: done=1 for exactly one cycle, then go to IDLE. Error flags clear when leaving DONE.
- Lane rules, off = addr[1:0]:
  - mem_be: byte 0001<<off; half 0011<<off; word 1111.
  - mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
  - Load extraction: byte mem_rdata[8*off+:8]; half mem_rdata[8*off+:16]. Extend per sign_ext.
- rdata changes only on a successful load. Stores and errors leave it untouched.
- start while busy or in DONE is ignored; no queuing.
- Reset: all outputs 0, rdata=0, counter=0, state IDLE. Assertion mid-REQ drops mem_req immediately (async). No done is produced for the aborted access.

## Timing
- All outputs are registered.
- Start accepted at edge 0: mem_req and busy are high in cycle 1.
- mem_ack high in cycle k (k≥1): done is high in cycle k+1, and rdata is valid from cycle k+1.
- Minimum start-to-done latency is 2 cycles. With w wait cycles it is 2+w.
- Misaligned start: done and err_misalign are high in cycle 1, with busy=0 throughout.
- Timeout: mem_req is high for exactly TIMEOUT cycles (1..TIMEOUT). done and err_timeout are high the following cycle.
- mem_ack in the same cycle the counter hits TIMEOUT counts as success; ack takes priority.
- mem_ack outside REQ is ignored.
- A new start is accepted at the earliest in the cycle after done.

## Structure
- Shared package mem_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - FSM state enum
  - default TIMEOUT constant
- Sub-module lane_align, purely combinational, computes mem_be and mem_wdata from size/off/wdata, and load extraction/extension from mem_rdata/size/off/sign_ext. It is instantiated once and verified standalone.

## Test plan
- Word store: addr=0x100, wdata=0xDEADBEEF, ack after 2 wait cycles -> mem_be=1111, mem_addr=0x100, mem_we=1, done in cycle 4, no errors, rdata unchanged.
- Byte load, sign-extend: addr=0x203, mem_rdata=0x80112233, sign_ext=1, immediate ack -> mem_be=1000, rdata=0xFFFFFF80, done in cycle 2. Same access with sign_ext=0 -> rdata=0x00000080.
- Half store: addr=0x12, wdata=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x10.
- Misaligned half load, addr=0x13 -> done and err_misalign in cycle 1, mem_req never asserted, rdata unchanged.
- Timeout with TIMEOUT=4, no ack -> mem_req high for 4 cycles, done and err_timeout in cycle 5. A start pulsed during REQ is ignored.
- rst_n low in the 2nd REQ cycle -> mem_req, busy and done go to 0 immediately, rdata=0. A new start after release completes normally.
